// File: rtl/shift_reg_univ.sv
// Universal shift register with parallel load, logical, arithmetic and rotate
// shifts in both directions, a configurable bit-step per shift, and a built-in
// shift counter. The counter raises done on the shift that completes one full
// pass of WIDTH/STEP shifts.
module shift_reg_univ #(
    parameter  int WIDTH  = 8,
    parameter  int STEP   = 1,
    parameter  int LOCK   = 1,
    localparam int NSHIFT = WIDTH / STEP,
    localparam int CW     = $clog2(NSHIFT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [STEP-1:0]  sin,
    input  logic [WIDTH-1:0] dp,
    output logic [WIDTH-1:0] q,
    output logic [STEP-1:0]  sout_r,
    output logic [STEP-1:0]  sout_l,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SRL  = 3'b010;
    localparam logic [2:0] M_SLL  = 3'b011;
    localparam logic [2:0] M_SRA  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ROL  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    localparam logic [CW-1:0] NSHIFT_C = CW'(NSHIFT);
    localparam logic          LOCK_C   = (LOCK != 0) ? 1'b1 : 1'b0;

    typedef enum logic {
        COUNTING = 1'b0,
        FULL     = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_reg, q_nxt;
    logic [WIDTH-1:0] shift_val;
    logic [CW-1:0]    cnt_reg, cnt_nxt;
    logic             is_shift;

    // Shifted value for the current mode; HOLD/LOAD/CLR fall back to q.
    always_comb begin
        shift_val = q_reg;
        is_shift  = 1'b1;
        case (mode)
            M_SRL:   shift_val = {sin, q_reg[WIDTH-1:STEP]};
            M_SLL:   shift_val = {q_reg[WIDTH-STEP-1:0], sin};
            M_SRA:   shift_val = {{STEP{q_reg[WIDTH-1]}}, q_reg[WIDTH-1:STEP]};
            M_ROR:   shift_val = {q_reg[STEP-1:0], q_reg[WIDTH-1:STEP]};
            M_ROL:   shift_val = {q_reg[WIDTH-STEP-1:0], q_reg[WIDTH-1:WIDTH-STEP]};
            default: is_shift  = 1'b0;
        endcase
    end

    // Next register contents, shift count and pass state.
    always_comb begin
        q_nxt     = q_reg;
        cnt_nxt   = cnt_reg;
        state_nxt = state;
        if (!en) begin
            q_nxt = q_reg;
        end else if (mode == M_LOAD) begin
            q_nxt     = dp;
            cnt_nxt   = '0;
            state_nxt = COUNTING;
        end else if (mode == M_CLR) begin
            q_nxt     = '0;
            cnt_nxt   = '0;
            state_nxt = COUNTING;
        end else if (is_shift) begin
            // A locked register ignores shifts once the pass is complete.
            if (LOCK_C && (state == FULL)) begin
                q_nxt = q_reg;
            end else begin
                q_nxt = shift_val;
                if (cnt_reg != NSHIFT_C) begin
                    cnt_nxt = cnt_reg + CW'(1);
                end else begin
                    cnt_nxt = cnt_reg;
                end
                if ((cnt_reg + CW'(1)) == NSHIFT_C) begin
                    state_nxt = FULL;
                end else begin
                    state_nxt = state;
                end
            end
        end else begin
            q_nxt = q_reg;
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg   <= '0;
            cnt_reg <= '0;
            state   <= COUNTING;
        end else begin
            q_reg   <= q_nxt;
            cnt_reg <= cnt_nxt;
            state   <= state_nxt;
        end
    end

    assign q      = q_reg;
    assign cnt    = cnt_reg;
    assign done   = (state == FULL);
    assign sout_r = q_reg[STEP-1:0];
    assign sout_l = q_reg[WIDTH-1:WIDTH-STEP];

    logic unused_hold;
    assign unused_hold = (M_HOLD == 3'b000);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: three instances (8/1 locked, 8/2 locked,
// 8/1 free-running) driven by shared stimulus, each tracked by a
// behavioural model and compared every cycle, plus literal expectations.
module tb_shift_reg_univ;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [2:0] mode;
    logic [1:0] sin;
    logic [7:0] dp;

    logic [7:0] qa, qb, qc;
    logic       sra_o, sla_o, src_o, slc_o;
    logic [1:0] srb_o, slb_o;
    logic [3:0] cnta, cntc;
    logic [2:0] cntb;
    logic       donea, doneb, donec;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(8), .STEP(1), .LOCK(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin[0:0]), .dp(dp),
        .q(qa), .sout_r(sra_o), .sout_l(sla_o), .cnt(cnta), .done(donea));
    shift_reg_univ #(.WIDTH(8), .STEP(2), .LOCK(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .dp(dp),
        .q(qb), .sout_r(srb_o), .sout_l(slb_o), .cnt(cntb), .done(doneb));
    shift_reg_univ #(.WIDTH(8), .STEP(1), .LOCK(0)) dut_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin[0:0]), .dp(dp),
        .q(qc), .sout_r(src_o), .sout_l(slc_o), .cnt(cntc), .done(donec));

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] cnt;
        logic        done;
    } mst_t;

    mst_t ma = '0, mb = '0, mc = '0;

    // Reference behaviour computed with plain arithmetic on 32-bit values.
    function automatic mst_t mstep(mst_t cur, int w, int s, bit lock, logic r_i,
                                   logic e_i, logic [2:0] md, logic [31:0] sn,
                                   logic [31:0] dpv);
        mst_t n = cur;
        int nsh = w / s;
        logic [31:0] mask  = (32'd1 << w) - 32'd1;
        logic [31:0] smask = (32'd1 << s) - 32'd1;
        logic [31:0] sv    = sn & smask;
        if (r_i) n = '0;
        else if (e_i) begin
            if (md == 3'd1) begin
                n.q = dpv & mask; n.cnt = 0; n.done = 1'b0;
            end else if (md == 3'd7) begin
                n = '0;
            end else if (md != 3'd0 && !(lock && cur.done)) begin
                case (md)
                    3'd2: n.q = ((cur.q >> s) | (sv << (w - s))) & mask;
                    3'd3: n.q = ((cur.q << s) | sv) & mask;
                    3'd4: n.q = cur.q[w-1] ? ((cur.q >> s) | (smask << (w - s))) & mask
                                           : (cur.q >> s);
                    3'd5: n.q = ((cur.q >> s) | (cur.q << (w - s))) & mask;
                    3'd6: n.q = ((cur.q << s) | (cur.q >> (w - s))) & mask;
                    default: n.q = cur.q;
                endcase
                if (cur.cnt < nsh) n.cnt = cur.cnt + 1;
                if (n.cnt == nsh) n.done = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input mst_t m, input int w, input int s,
                            input logic [31:0] q, input logic [31:0] c, input logic d,
                            input logic [31:0] sr, input logic [31:0] sl);
        logic [31:0] smask = (32'd1 << s) - 32'd1;
        check({tag, ".q"}, q, m.q);
        check({tag, ".cnt"}, c, m.cnt);
        check({tag, ".done"}, {31'd0, d}, {31'd0, m.done});
        check({tag, ".sout_r"}, sr, m.q & smask);
        check({tag, ".sout_l"}, sl, (m.q >> (w - s)) & smask);
    endtask

    // Models advance on the same edge as the DUTs.
    always @(posedge clk) begin
        ma <= mstep(ma, 8, 1, 1'b1, rst, en, mode, {30'd0, sin}, {24'd0, dp});
        mb <= mstep(mb, 8, 2, 1'b1, rst, en, mode, {30'd0, sin}, {24'd0, dp});
        mc <= mstep(mc, 8, 1, 1'b0, rst, en, mode, {30'd0, sin}, {24'd0, dp});
    end

    // Every-cycle comparison against the models, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp_inst("A", ma, 8, 1, qa, cnta, donea, sra_o, sla_o);
            cmp_inst("B", mb, 8, 2, qb, cntb, doneb, srb_o, slb_o);
            cmp_inst("C", mc, 8, 1, qc, cntc, donec, src_o, slc_o);
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                       input logic [1:0] s, input logic [7:0] d);
        @(negedge clk);
        rst = r; en = e; mode = m; sin = s; dp = d;
        @(posedge clk);
        #1;
    endtask

    bit exp_sr [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'd0; sin = 2'd0; dp = 8'd0;
        // Reset, then load
        cyc(1'b1, 1'b0, 3'd0, 2'd0, 8'h00);
        chk_on = 1'b1;
        check("t1.q_rst", {24'd0, qa}, 32'h00);
        check("t1.cnt_rst", {28'd0, cnta}, 32'd0);
        check("t1.done_rst", {31'd0, donea}, 32'd0);
        cyc(1'b0, 1'b1, 3'd1, 2'd0, 8'hB5);
        check("t1.q_load", {24'd0, qa}, 32'hB5);
        check("t1.sout_r", {31'd0, sra_o}, 32'd1);
        check("t1.sout_l", {31'd0, sla_o}, 32'd1);
        // Eight SRLs draining the register through sout_r
        for (int i = 0; i < 8; i++) begin
            check("t2.sout_r_seq", {31'd0, sra_o}, {31'd0, exp_sr[i]});
            cyc(1'b0, 1'b1, 3'd2, 2'd0, 8'h00);
            check("t2.done_edge", {31'd0, donea}, (i == 7) ? 32'd1 : 32'd0);
        end
        check("t2.q_end", {24'd0, qa}, 32'h00);
        check("t2.cnt_end", {28'd0, cnta}, 32'd8);
        cyc(1'b0, 1'b1, 3'd2, 2'd1, 8'h00);
        check("t2.lock_q", {24'd0, qa}, 32'h00);
        check("t2.lock_cnt", {28'd0, cnta}, 32'd8);
        check("t2.lock_done", {31'd0, donea}, 32'd1);
        // STEP=2 arithmetic / rotate / logical shifts
        cyc(1'b0, 1'b1, 3'd1, 2'd0, 8'h96);
        cyc(1'b0, 1'b1, 3'd4, 2'd0, 8'h00);
        check("t3.sra", {24'd0, qb}, 32'hE5);
        cyc(1'b0, 1'b1, 3'd6, 2'd0, 8'h00);
        check("t3.rol", {24'd0, qb}, 32'h97);
        cyc(1'b0, 1'b1, 3'd3, 2'd3, 8'h00);
        check("t3.sll", {24'd0, qb}, 32'h5F);
        check("t3.cnt3", {29'd0, cntb}, 32'd3);
        check("t3.done3", {31'd0, doneb}, 32'd0);
        cyc(1'b0, 1'b1, 3'd2, 2'd0, 8'h00);
        check("t3.done4", {31'd0, doneb}, 32'd1);
        check("t3.q4", {24'd0, qb}, 32'h17);
        // Enable gating on ROR
        cyc(1'b0, 1'b1, 3'd1, 2'd0, 8'h81);
        cyc(1'b0, 1'b1, 3'd5, 2'd0, 8'h00);
        check("t4.ror1", {24'd0, qa}, 32'hC0);
        cyc(1'b0, 1'b0, 3'd5, 2'd0, 8'h00);
        check("t4.hold1", {24'd0, qa}, 32'hC0);
        cyc(1'b0, 1'b1, 3'd5, 2'd0, 8'h00);
        check("t4.ror2", {24'd0, qa}, 32'h60);
        cyc(1'b0, 1'b0, 3'd5, 2'd0, 8'h00);
        check("t4.hold2", {24'd0, qa}, 32'h60);
        check("t4.cnt", {28'd0, cnta}, 32'd2);
        // Reset mid-pass, then LOAD and CLR
        cyc(1'b0, 1'b1, 3'd1, 2'd0, 8'h5A);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 3'd2, 2'd1, 8'h00);
        cyc(1'b1, 1'b1, 3'd2, 2'd1, 8'h00);
        check("t5.q_rst", {24'd0, qa}, 32'h00);
        check("t5.cnt_rst", {28'd0, cnta}, 32'd0);
        check("t5.done_rst", {31'd0, donea}, 32'd0);
        cyc(1'b0, 1'b1, 3'd1, 2'd0, 8'hAA);
        cyc(1'b0, 1'b1, 3'd7, 2'd0, 8'h00);
        check("t5.q_clr", {24'd0, qa}, 32'h00);
        check("t5.cnt_clr", {28'd0, cnta}, 32'd0);
        // LOCK=0 keeps shifting after done
        cyc(1'b0, 1'b1, 3'd1, 2'd0, 8'hB5);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 3'd2, 2'd1, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 3'd2, 2'd0, 8'h00);
        check("t6.c_q", {24'd0, qc}, 32'h1F);
        check("t6.c_cnt", {28'd0, cntc}, 32'd8);
        check("t6.c_done", {31'd0, donec}, 32'd1);
        check("t6.a_locked", {24'd0, qa}, 32'hFF);
        cyc(1'b0, 1'b1, 3'd1, 2'd0, 8'h3C);
        check("t6.c_reload_q", {24'd0, qc}, 32'h3C);
        check("t6.c_reload_cnt", {28'd0, cntc}, 32'd0);
        check("t6.c_reload_done", {31'd0, donec}, 32'd0);
        // Randomised traffic, checked by the every-cycle compare
        for (int i = 0; i < 3000; i++) begin
            int r8;
            logic [2:0] m;
            r8 = int'($urandom_range(0, 15));
            m  = (r8 < 8) ? 3'(r8) : 3'(2 + (r8 % 5));
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), m,
                2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
